// File: rtl/regs_file.sv
// Architectural integer register file: two bypassed combinational read ports,
// one write-back write port and a handshaked debug access port that yields to write-back.
module regs_file #(
  parameter int          REG_NUM   = 32,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        regs_wen_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic [4:0]  rs1_raddr_i,
  output logic [31:0] rs1_rdata_o,
  input  logic [4:0]  rs2_raddr_i,
  output logic [31:0] rs2_rdata_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_rdata_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK,
    HOLD
  } dbg_state_e;

  dbg_state_e  state_q, state_d;
  logic [31:0] regs_q [REG_NUM];
  logic [31:0] regs_d [REG_NUM];
  logic        dbg_ack_q, dbg_ack_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        dbg_exec;

  // Debug only touches the array in an ACCESS cycle that write-back leaves free.
  assign dbg_exec = (state_q == ACCESS) && !regs_wen_i;

  always_comb begin
    rs1_rdata_o = regs_q[rs1_raddr_i];
    if (rs1_raddr_i == 5'd0) begin
      rs1_rdata_o = '0;
    end else if (regs_wen_i && (rs1_raddr_i == rd_addr_i)) begin
      rs1_rdata_o = rd_data_i;
    end

    rs2_rdata_o = regs_q[rs2_raddr_i];
    if (rs2_raddr_i == 5'd0) begin
      rs2_rdata_o = '0;
    end else if (regs_wen_i && (rs2_raddr_i == rd_addr_i)) begin
      rs2_rdata_o = rd_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (regs_wen_i && (rd_addr_i != 5'd0)) begin
      regs_d[rd_addr_i] = rd_data_i;
    end else if (dbg_exec && dbg_we_i && (dbg_addr_i != 5'd0)) begin
      regs_d[dbg_addr_i] = dbg_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (dbg_req_i) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (dbg_exec) begin
          state_d   = ACK;
          dbg_ack_d = 1'b1;
          if (!dbg_we_i) begin
            dbg_rdata_d = (dbg_addr_i == 5'd0) ? 32'h0 : regs_q[dbg_addr_i];
          end
        end
      end
      ACK: begin
        state_d = dbg_req_i ? HOLD : IDLE;
      end
      HOLD: begin
        if (!dbg_req_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ack and read data are registered so the ack pulse coincides with the ACK state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_ack_o   = dbg_ack_q;
  assign dbg_rdata_o = dbg_rdata_q;

endmodule
